instr_fetch_unit: RTL and testbench

Upstream feeder for the CPU core. Holds a loadable program memory of 9-bit instructions and issues them to the CPU's 9-bit instruction input, one per clock, under a start/stall/abort handshake.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_prog_mem.sv | 18 +
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction format, opcodes and fetch FSM encoding.
package cpu_pkg;
    localparam int INSTR_W = 9;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;
    localparam int OPC_MSB  = 8;
    localparam int OPC_LSB  = 7;
    localparam int REG_MSB  = 6;
    localparam int REG_LSB  = 5;
    localparam int ADDR_MSB = 4;
    localparam int ADDR_LSB = 0;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;
    function automatic logic [INSTR_W-1:0] mk_instr(input logic [1:0] opc, input logic [1:0] rsel, input logic [4:0] addr);
        return {opc, rsel, addr};
    endfunction
endpackage

// File: rtl/instr_prog_mem.sv
// instr_prog_mem: program store with synchronous write and combinational read.
module instr_prog_mem #(
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);
    logic [INSTR_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues a loaded program to the CPU one word per clock
// under a start/stall/abort handshake.
module instr_fetch_unit #(
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int DEPTH   = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    input  logic               stall,
    input  logic               abort,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [AW:0]        pc,
    output logic               busy,
    output logic               done
);
    import cpu_pkg::*;
    localparam logic [AW:0] L_ONE = (AW+1)'(1);
    fetch_state_t       r_state, w_next;
    logic [INSTR_W-1:0] r_instr, w_rd_data;
    logic [AW:0]        r_pc, r_len, w_pc_inc;
    logic [AW-1:0]      w_rd_addr;
    logic               r_valid, r_done, w_start_ok, w_fetch, w_clear, w_done;
    assign busy       = r_state != ST_IDLE;
    assign w_pc_inc   = r_pc + L_ONE;
    assign w_start_ok = (r_state == ST_IDLE) && start && (prog_len != '0);
    // Starts always fetch word 0, regardless of where the last run left pc.
    assign w_rd_addr  = (r_state == ST_IDLE) ? '0 : r_pc[AW-1:0];
    instr_prog_mem #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (prog_we && !busy),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) begin
            if (w_start_ok) w_next = (prog_len > L_ONE) ? ST_RUN : ST_DRAIN;
        end else if (abort) begin
            w_next = ST_IDLE;
        end else if (!stall) begin
            w_next = (r_state == ST_DRAIN) ? ST_IDLE : (w_pc_inc == r_len) ? ST_DRAIN : ST_RUN;
        end
    end
    always_comb begin
        w_fetch = w_start_ok || (r_state == ST_RUN && !abort && !stall);
        w_clear = busy && (abort || (r_state == ST_DRAIN && !stall));
        w_done  = w_clear || (r_state == ST_IDLE && start && prog_len == '0);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_instr <= '0;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_fetch) begin
                r_instr <= w_rd_data;
                r_valid <= 1'b1;
                r_pc    <= w_start_ok ? L_ONE : w_pc_inc;
            end else if (w_clear) begin
                r_instr <= '0;
                r_valid <= 1'b0;
            end
            if (w_start_ok) r_len <= prog_len;
        end
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign done        = r_done;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized runs checked against a
// program-array model of the expected issue trace.
module tb_instr_fetch_unit;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int W = 9;
    logic clk = 0, rst = 1, prog_we = 0, start = 0, stall = 0, abort = 0;
    logic [AW-1:0] prog_addr = '0;
    logic [W-1:0] prog_data = '0;
    logic [AW:0] prog_len = '0;
    logic [W-1:0] instr;
    logic instr_valid, busy, done;
    logic [AW:0] pc;
    int checks = 0, failures = 0;
    logic [W-1:0] model [DEPTH];

    instr_fetch_unit #(.INSTR_W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .stall(stall), .abort(abort), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        prog_we = 1; prog_addr = a[AW-1:0]; prog_data = d;
        tick;
        prog_we = 0;
        model[a] = d;
    endtask

    // act: 0 none, 1 abort, 2 reset, applied on first presentation of word act_at
    task automatic run(input int len, input int pct, input int st_at, input int st_n,
                       input int act_at, input int act, input bit we_busy,
                       input bit wr0, input logic [W-1:0] wr0_d);
        logic [W-1:0] exp [DEPTH];
        int idx = 0, held = 0, guard = 0;
        bit s;
        exp = model;
        prog_len = len[AW:0];
        start = 1;
        if (wr0) begin
            prog_we = 1; prog_addr = '0; prog_data = wr0_d; model[0] = wr0_d;
        end
        tick;
        start = 0; prog_we = 0;
        if (len == 0) begin
            chk("zl_valid", 32'(instr_valid), 0);
            chk("zl_done", 32'(done), 1);
            chk("zl_busy", 32'(busy), 0);
            tick;
            chk("zl_done_off", 32'(done), 0);
            chk("zl_busy_off", 32'(busy), 0);
            return;
        end
        if (we_busy) begin
            prog_we = 1; prog_addr = 5'd2; prog_data = 9'b100000000;
        end
        while (idx < len && guard < 400) begin
            guard++;
            chk("valid", 32'(instr_valid), 1);
            chk("instr", 32'(instr), 32'(exp[idx]));
            chk("pc", 32'(pc), idx + 1);
            chk("busy", 32'(busy), 1);
            chk("done", 32'(done), 0);
            if (act == 1 && idx == act_at) begin
                abort = 1; stall = 1'($urandom_range(1)); start = 1'($urandom_range(1));
                tick;
                abort = 0; stall = 0; start = 0; prog_we = 0;
                chk("ab_valid", 32'(instr_valid), 0);
                chk("ab_instr", 32'(instr), 0);
                chk("ab_done", 32'(done), 1);
                chk("ab_pc", 32'(pc), idx + 1);
                chk("ab_busy", 32'(busy), 0);
                tick;
                chk("ab_done_off", 32'(done), 0);
                chk("ab_valid_off", 32'(instr_valid), 0);
                return;
            end
            if (act == 2 && idx == act_at) begin
                #2 rst = 1;
                #1;
                chk("rs_valid", 32'(instr_valid), 0);
                chk("rs_instr", 32'(instr), 0);
                chk("rs_pc", 32'(pc), 0);
                chk("rs_busy", 32'(busy), 0);
                chk("rs_done", 32'(done), 0);
                tick;
                chk("rs_done_hold", 32'(done), 0);
                rst = 0;
                tick;
                chk("rs_done_after", 32'(done), 0);
                chk("rs_valid_after", 32'(instr_valid), 0);
                return;
            end
            s = (idx == st_at && held < st_n) || ($urandom_range(99) < pct);
            if (idx == st_at && s) held++;
            stall = s;
            tick;
            if (!s) idx++;
        end
        stall = 0; prog_we = 0;
        if (guard >= 400) chk("guard", 0, 1);
        chk("end_valid", 32'(instr_valid), 0);
        chk("end_instr", 32'(instr), 0);
        chk("end_done", 32'(done), 1);
        chk("end_pc", 32'(pc), len);
        chk("end_busy", 32'(busy), 0);
        tick;
        chk("end_done_off", 32'(done), 0);
    endtask

    initial begin
        logic [W-1:0] prog [8];
        int n;
        prog = '{9'b000011110, 9'b000111111, 9'b110000000, 9'b011001010,
                 9'b011100101, 9'b100000000, 9'b011010100, 9'b011111001};
        tick;
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 0;
        tick;
        for (int i = 0; i < DEPTH; i++) wr(i, (i < 8) ? prog[i] : W'($urandom));
        run(8, 0, -1, 0, -1, 0, 0, 0, '0);
        run(8, 0, 2, 3, -1, 0, 0, 0, '0);
        run(8, 0, -1, 0, 3, 1, 0, 0, '0);
        run(8, 0, -1, 0, -1, 0, 0, 0, '0);
        run(0, 0, -1, 0, -1, 0, 0, 0, '0);
        run(1, 0, -1, 0, -1, 0, 0, 0, '0);
        run(8, 0, -1, 0, -1, 0, 1, 0, '0);
        run(8, 0, -1, 0, -1, 0, 0, 0, '0);
        wr(2, 9'b100000000);
        run(8, 0, -1, 0, -1, 0, 0, 0, '0);
        wr(2, 9'b110000000);
        run(8, 0, -1, 0, 4, 2, 0, 0, '0);
        run(8, 0, -1, 0, -1, 0, 0, 0, '0);
        run(8, 0, -1, 0, -1, 0, 0, 1, W'($urandom));
        run(8, 0, -1, 0, -1, 0, 0, 0, '0);
        run(DEPTH, 30, -1, 0, -1, 0, 0, 0, '0);
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(DEPTH));
            run(n, 25, -1, 0, -1, 0, 1'($urandom_range(1)), 0, '0);
        end
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(DEPTH, 2));
            run(n, 20, -1, 0, int'($urandom_range(n - 1)), 1, 0, 0, '0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
